// File: rtl/logic_arb_pkg.sv
// Shared types for the two-requester logic-unit arbiter: opcodes, FSM states
// and the requester count.
package logic_arb_pkg;

  typedef enum logic [1:0] {
    AND    = 2'b00,
    OR     = 2'b01,
    XOR    = 2'b10,
    PASS_A = 2'b11
  } logic_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  localparam int NUM_REQ = 2;

endpackage

// File: rtl/logic_unit.sv
// Combinational bitwise logic cell: AND / OR / XOR / pass-through of operand a.
module logic_unit
  import logic_arb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic_op_t          op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   y
);

  always_comb begin
    y = a;
    case (op)
      AND:     y = a & b;
      OR:      y = a | b;
      XOR:     y = a ^ b;
      PASS_A:  y = a;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logic_unit between two valid/ready requesters,
// with a registered result and a wrapping completion counter.
//
// state | meaning
// IDLE  | no operation held; grant offered combinationally on req_ready
// RESP  | result registered for owner, waiting for rsp_ready[owner]
module logic_unit_arbiter
  import logic_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [1:0]           req_op0,
  input  logic [1:0]           req_op1,
  input  logic [WIDTH-1:0]     req_a0,
  input  logic [WIDTH-1:0]     req_b0,
  input  logic [WIDTH-1:0]     req_a1,
  input  logic [WIDTH-1:0]     req_b1,
  output logic [NUM_REQ-1:0]   rsp_valid,
  input  logic [NUM_REQ-1:0]   rsp_ready,
  output logic [WIDTH-1:0]     rsp_data,
  output logic                 busy,
  output logic [CNT_W-1:0]     done_cnt
);

  state_t             state, state_d;
  logic [NUM_REQ-1:0] grant;
  logic               sel;
  logic               owner;
  logic               last_grant;
  logic               accept;
  logic               rsp_hs;
  logic_op_t          op_sel;
  logic [WIDTH-1:0]   a_sel, b_sel, y;

  // On a tie, the requester that did not win last time gets the grant.
  always_comb begin
    grant = '0;
    if (state == IDLE) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  assign req_ready = grant;
  assign sel       = grant[1];
  assign accept    = |(req_valid & grant);
  assign rsp_hs    = rsp_valid[owner] & rsp_ready[owner];
  assign busy      = (state == RESP);

  assign op_sel = logic_op_t'(sel ? req_op1 : req_op0);
  assign a_sel  = sel ? req_a1 : req_a0;
  assign b_sel  = sel ? req_b1 : req_b0;

  logic_unit #(.WIDTH(WIDTH)) u_logic_unit (
    .op (op_sel),
    .a  (a_sel),
    .b  (b_sel),
    .y  (y)
  );

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept) state_d = RESP;
      RESP:    if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      done_cnt   <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state <= state_d;
      if (accept) begin
        rsp_data   <= y;
        rsp_valid  <= grant;
        owner      <= sel;
        last_grant <= sel;
      end else if (rsp_hs) begin
        rsp_valid <= '0;
        done_cnt  <= done_cnt + CNT_W'(1);
      end
    end
  end

endmodule
